// File: rtl/rv_float_round_pipe.sv
// rv_float_round_pipe: two-stage rounding of a wide normalised mantissa to target precision with RISC-V fflags
module rv_float_round_pipe #(
   parameter int unsigned EXP_WIDTH      = 16,
   parameter int unsigned MANT_WIDTH     = 112,
   parameter int unsigned OUT_MANT_WIDTH = 53,
   parameter int unsigned EXP_MAX        = 2047
) (
   input  logic                      clk_i,
   input  logic                      arst_ni,
   input  logic [2:0]                rm_i,
   input  logic                      sign_i,
   input  logic [EXP_WIDTH-1:0]      exponent_i,
   input  logic [MANT_WIDTH-1:0]     mantissa_i,
   input  logic                      overflow_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   output logic                      sign_o,
   output logic [EXP_WIDTH-1:0]      exponent_o,
   output logic [OUT_MANT_WIDTH-1:0] mantissa_o,
   output logic [4:0]                flags_o,
   output logic                      valid_o,
   input  logic                      ready_i
);
   localparam int unsigned G = MANT_WIDTH - OUT_MANT_WIDTH - 1;
   localparam logic [2:0] RNE = 3'd0, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
   localparam logic [EXP_WIDTH:0] EMAX = (EXP_WIDTH+1)'(EXP_MAX);
   localparam logic [EXP_WIDTH-1:0] EMAX_M1 = EXP_WIDTH'(EXP_MAX - 1);

   typedef struct packed {
      logic                      sign;
      logic [EXP_WIDTH-1:0]      exp;
      logic [OUT_MANT_WIDTH-1:0] kept;
      logic                      inc;
      logic                      nx;
      logic                      of;
      logic                      nv;
      logic                      tiny;
      logic [2:0]                rm;
   } s1_t;

   typedef struct packed {
      logic                      sign;
      logic [EXP_WIDTH-1:0]      exp;
      logic [OUT_MANT_WIDTH-1:0] mant;
      logic [4:0]                flags;
   } s2_t;

   s1_t s1_d, s1_q, s1_new;
   s2_t s2_d, s2_q, s2_new;
   logic s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q, s2_ready;
   logic guard, sticky;
   logic [OUT_MANT_WIDTH:0] sum;
   logic [EXP_WIDTH:0] exp_r;
   logic ovf, to_inf;

   // stage 1: split fields, choose increment per rounding mode, capture when the stage can advance
   always_comb begin
      s2_ready = !s2_valid_q | ready_i;
      ready_o = !s1_valid_q | s2_ready;
      guard = mantissa_i[G];
      sticky = |mantissa_i[G-1:0];
      s1_new.sign = sign_i;
      s1_new.exp = exponent_i;
      s1_new.kept = mantissa_i[MANT_WIDTH-1 -: OUT_MANT_WIDTH];
      s1_new.nx = guard | sticky;
      s1_new.of = overflow_i;
      s1_new.nv = rm_i > RMM;
      s1_new.tiny = exponent_i == '0;
      s1_new.rm = s1_new.nv ? RNE : rm_i;
      s1_new.inc = (s1_new.rm == RNE) ? guard & (sticky | s1_new.kept[0]) :
                   (s1_new.rm == RDN) ? sign_i & s1_new.nx :
                   (s1_new.rm == RUP) ? !sign_i & s1_new.nx :
                   (s1_new.rm == RMM) ? guard : 1'b0;
      s1_valid_d = ready_o ? valid_i : s1_valid_q;
      s1_d = (ready_o & valid_i) ? s1_new : s1_q;
   end

   // stage 2: apply increment, renormalise on carry, saturate or go to Inf on overflow
   always_comb begin
      sum = {1'b0, s1_q.kept} + {{OUT_MANT_WIDTH{1'b0}}, s1_q.inc};
      exp_r = {1'b0, s1_q.exp} + {{EXP_WIDTH{1'b0}}, sum[OUT_MANT_WIDTH]};
      ovf = s1_q.of | (exp_r >= EMAX);
      to_inf = (s1_q.rm == RNE) | (s1_q.rm == RMM) | ((s1_q.rm == RUP) & !s1_q.sign) |
               ((s1_q.rm == RDN) & s1_q.sign);
      s2_new.sign = s1_q.sign;
      s2_new.exp = ovf ? (to_inf ? EMAX[EXP_WIDTH-1:0] : EMAX_M1) : exp_r[EXP_WIDTH-1:0];
      s2_new.mant = ovf ? (to_inf ? '0 : '1) :
                    sum[OUT_MANT_WIDTH] ? {1'b1, {(OUT_MANT_WIDTH-1){1'b0}}} : sum[OUT_MANT_WIDTH-1:0];
      s2_new.flags = {s1_q.nv, 1'b0, ovf, s1_q.tiny & s1_q.nx, s1_q.nx | ovf};
      s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
      s2_d = s2_ready ? s2_new : s2_q;
   end

   // pipeline registers; reset discards in-flight items and clears outputs
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign valid_o = s2_valid_q;
   assign sign_o = s2_q.sign;
   assign exponent_o = s2_q.exp;
   assign mantissa_o = s2_q.mant;
   assign flags_o = s2_q.flags;
endmodule

// File: tb/tb_rv_float_round_pipe.sv
// tb_rv_float_round_pipe: directed vectors for rounding, overflow, flags, backpressure and async reset
module tb_rv_float_round_pipe;
   logic         clk_i = 1'b0;
   logic         arst_ni;
   logic [2:0]   rm_i;
   logic         sign_i;
   logic [15:0]  exponent_i;
   logic [111:0] mantissa_i;
   logic         overflow_i;
   logic         valid_i;
   logic         ready_o;
   logic         sign_o;
   logic [15:0]  exponent_o;
   logic [52:0]  mantissa_o;
   logic [4:0]   flags_o;
   logic         valid_o;
   logic         ready_i;

   int n_total = 0;
   int n_pass = 0;

   localparam logic [52:0] ALL1 = {53{1'b1}};
   localparam logic [52:0] HID = {1'b1, 52'd0};

   rv_float_round_pipe dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .rm_i(rm_i), .sign_i(sign_i),
      .exponent_i(exponent_i), .mantissa_i(mantissa_i), .overflow_i(overflow_i),
      .valid_i(valid_i), .ready_o(ready_o), .sign_o(sign_o), .exponent_o(exponent_o),
      .mantissa_o(mantissa_o), .flags_o(flags_o), .valid_o(valid_o), .ready_i(ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h", tag, got, exp);
   endtask

   task automatic drive(input logic [2:0] rm, input logic sg, input logic [15:0] ex,
                        input logic [52:0] kept, input logic g, input logic st, input logic ov);
      rm_i = rm;
      sign_i = sg;
      exponent_i = ex;
      mantissa_i = {kept, g, 57'd0, st};
      overflow_i = ov;
      valid_i = 1'b1;
   endtask

   task automatic run_one(input string tag, input logic [2:0] rm, input logic sg, input logic [15:0] ex,
                          input logic [52:0] kept, input logic g, input logic st, input logic ov,
                          input logic [15:0] e_exp, input logic [52:0] e_mant, input logic [4:0] e_fl);
      drive(rm, sg, ex, kept, g, st, ov);
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      check({tag, "_lat1"}, 64'(valid_o), 64'd0);
      @(posedge clk_i);
      #1;
      check({tag, "_valid"}, 64'(valid_o), 64'd1);
      check({tag, "_exp"}, 64'(exponent_o), 64'(e_exp));
      check({tag, "_mant"}, 64'(mantissa_o), 64'(e_mant));
      check({tag, "_flags"}, 64'(flags_o), 64'(e_fl));
      check({tag, "_sign"}, 64'(sign_o), 64'(sg));
   endtask

   logic [52:0] bp_exp [6];
   int idx, out_idx;
   logic acc, pop, saw_low;

   initial begin
      arst_ni = 1'b0;
      ready_i = 1'b1;
      valid_i = 1'b0;
      drive(3'd0, 1'b0, 16'd0, HID, 1'b0, 1'b0, 1'b0);
      valid_i = 1'b0;
      #12;
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_ready", 64'(ready_o), 64'd1);
      check("rst_data", 64'(mantissa_o), 64'd0);
      @(negedge clk_i) arst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      run_one("rne_even", 3'd0, 1'b0, 16'd100, HID | 53'h10, 1'b1, 1'b0, 1'b0, 16'd100, HID | 53'h10, 5'b00001);
      run_one("rne_odd", 3'd0, 1'b0, 16'd100, HID | 53'h1, 1'b1, 1'b0, 1'b0, 16'd100, HID | 53'h2, 5'b00001);
      run_one("carry", 3'd3, 1'b0, 16'd100, ALL1, 1'b1, 1'b0, 1'b0, 16'd101, HID, 5'b00001);
      run_one("ovf_rne", 3'd0, 1'b0, 16'd2046, ALL1, 1'b1, 1'b0, 1'b0, 16'd2047, 53'd0, 5'b00101);
      run_one("ovf_rtz", 3'd1, 1'b0, 16'd500, HID, 1'b0, 1'b0, 1'b1, 16'd2046, ALL1, 5'b00101);
      run_one("ovf_rdn_p", 3'd2, 1'b0, 16'd500, HID, 1'b0, 1'b0, 1'b1, 16'd2046, ALL1, 5'b00101);
      run_one("ovf_rdn_n", 3'd2, 1'b1, 16'd500, HID, 1'b0, 1'b0, 1'b1, 16'd2047, 53'd0, 5'b00101);
      run_one("ovf_exp", 3'd2, 1'b0, 16'd2047, HID, 1'b0, 1'b0, 1'b0, 16'd2046, ALL1, 5'b00101);
      for (int m = 0; m < 5; m++)
         run_one($sformatf("exact_rm%0d", m), 3'(m), 1'b1, 16'd300, HID | 53'h5, 1'b0, 1'b0, 1'b0,
                 16'd300, HID | 53'h5, 5'b00000);
      run_one("uf", 3'd0, 1'b0, 16'd0, HID, 1'b0, 1'b1, 1'b0, 16'd0, HID, 5'b00011);
      run_one("rm7", 3'd7, 1'b0, 16'd100, HID | 53'h1, 1'b1, 1'b0, 1'b0, 16'd100, HID | 53'h2, 5'b10001);
      run_one("rmm", 3'd4, 1'b1, 16'd40, HID, 1'b1, 1'b0, 1'b0, 16'd40, HID | 53'h1, 5'b00001);
      run_one("rtz_nx", 3'd1, 1'b0, 16'd40, HID | 53'h3, 1'b1, 1'b1, 1'b0, 16'd40, HID | 53'h3, 5'b00001);
      run_one("rdn_neg", 3'd2, 1'b1, 16'd40, HID | 53'h3, 1'b0, 1'b1, 1'b0, 16'd40, HID | 53'h4, 5'b00001);
      run_one("rup_neg", 3'd3, 1'b1, 16'd40, HID | 53'h3, 1'b0, 1'b1, 1'b0, 16'd40, HID | 53'h3, 5'b00001);
      @(posedge clk_i);
      #1;
      // backpressure stream: six exact RTZ items, ready_i low in cycles 3..5
      for (int i = 0; i < 6; i++) bp_exp[i] = HID | 53'(i * 7 + 1);
      idx = 0;
      out_idx = 0;
      saw_low = 1'b0;
      for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
         ready_i = !(cyc >= 3 && cyc <= 5);
         if (idx < 6) drive(3'd1, 1'b0, 16'(10 + idx), bp_exp[idx], 1'b0, 1'b0, 1'b0);
         else valid_i = 1'b0;
         @(negedge clk_i);
         acc = valid_i & ready_o;
         pop = valid_o & ready_i;
         if (!ready_o) saw_low = 1'b1;
         if (valid_o) begin
            check($sformatf("bp_mant%0d", out_idx), 64'(mantissa_o), 64'(bp_exp[out_idx]));
            check($sformatf("bp_exp%0d", out_idx), 64'(exponent_o), 64'(10 + out_idx));
         end
         if (pop) out_idx++;
         if (acc) idx++;
         @(posedge clk_i);
         #1;
      end
      valid_i = 1'b0;
      check("bp_count", 64'(out_idx), 64'd6);
      check("bp_ready_drop", 64'(saw_low), 64'd1);
      repeat (3) @(posedge clk_i);
      #1 check("bp_no_dup", 64'(valid_o), 64'd0);
      // reset while stalled with a valid result on the output
      ready_i = 1'b0;
      drive(3'd1, 1'b1, 16'd77, HID | 53'h9, 1'b0, 1'b0, 1'b0);
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      @(posedge clk_i);
      #1 check("stall_valid", 64'(valid_o), 64'd1);
      #2 arst_ni = 1'b0;
      #1;
      check("arst_valid", 64'(valid_o), 64'd0);
      check("arst_mant", 64'(mantissa_o), 64'd0);
      check("arst_exp", 64'(exponent_o), 64'd0);
      check("arst_flags", 64'(flags_o), 64'd0);
      check("arst_ready", 64'(ready_o), 64'd1);
      @(negedge clk_i) arst_ni = 1'b1;
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      run_one("post_rst", 3'd0, 1'b0, 16'd55, HID | 53'h1, 1'b1, 1'b1, 1'b0, 16'd55, HID | 53'h2, 5'b00001);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/rv_float_round_pipe.md
# rv_float_round_pipe

Parametrised, two-stage pipelined floating-point rounding unit for the RISC-V FPU datapath. It takes a normalised, wide intermediate result (sign, biased exponent, extended mantissa, overflow hint) and rounds it to the target precision under the five RISC-V rounding modes. It produces the rounded sign/exponent/mantissa plus RISC-V `fflags`. It sits between the arithmetic cores (add/mul/fma) and result packing, with valid/ready flow control on both sides.

## Interface
- `EXP_WIDTH`, 16: width of input/output biased exponent.
- `MANT_WIDTH`, 112: input mantissa width; MSB is the hidden bit (input is normalised).
- `OUT_MANT_WIDTH`, 53: output mantissa width including hidden bit; must satisfy `OUT_MANT_WIDTH + 2 <= MANT_WIDTH`.
- `EXP_MAX`, 2047: biased exponent encoding Inf/NaN in target format.
- `clk_i`  in  1  clock; all state on rising edge.
- `arst_ni`  in  1  reset, asynchronous, active-low.
- `rm_i`  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
- `sign_i`  in  1  operand sign.
- `exponent_i`  in  EXP_WIDTH  biased exponent.
- `mantissa_i`  in  MANT_WIDTH  normalised mantissa.
- `overflow_i`  in  1  upstream already overflowed.
- `valid_i` / `ready_o`  in / out  1  input handshake.
- `sign_o`  out  1  result sign.
- `exponent_o`  out  EXP_WIDTH  rounded exponent.
- `mantissa_o`  out  OUT_MANT_WIDTH  rounded mantissa.
- `flags_o`  out  5  `{NV,DZ,OF,UF,NX}`.
- `valid_o` / `ready_i`  out / in  1  output handshake.

## Operation
- Field split: `kept = mantissa_i[MANT_WIDTH-1 -: OUT_MANT_WIDTH]`, `guard = mantissa_i[MANT_WIDTH-OUT_MANT_WIDTH-1]`, `sticky = |` remaining lower bits. `inexact = guard|sticky`.
- Increment decision:
  - RNE: `guard & (sticky | kept[0])`.
  - RTZ: 0.
  - RDN: `sign & inexact`.
  - RUP: `!sign & inexact`.
  - RMM: `guard`.
- rm 5–7: treated as RNE; NV set.
- Stage 1 registers sign, exponent, kept, increment, inexact, overflow_i, NV, and `tiny = (exponent_i == 0)`.
- Stage 2 computes `sum = kept + inc` at width OUT_MANT_WIDTH+1.
  - On carry-out: mantissa = `1 << (OUT_MANT_WIDTH-1)`, exponent + 1.
- Overflow occurs when `overflow_i`, or when the final exponent is `>= EXP_MAX`. The result then depends on the mode:
  - To Inf (exponent EXP_MAX, mantissa 0): RNE, RMM; RUP with sign 0; RDN with sign 1.
  - Otherwise to max finite (exponent EXP_MAX-1, mantissa all ones).
  - OF and NX are set in both cases.
- Flags:
  - NX = inexact | overflow.
  - UF = tiny & inexact.
  - DZ = 0 always.
  - NV only for illegal rm.
- Sign passes through unchanged.

## Timing
- Latency: 2 cycles from the accepting edge (`valid_i & ready_o`) to `valid_o`. Throughput is 1 result per cycle with no stalls.
- Stage enables:
  - `s2_ready = !s2_valid | ready_i`.
  - `ready_o = !s1_valid | s2_ready` (combinational, no bubble).
- A stalled stage holds all its registers. Outputs are stable while `valid_o & !ready_i`.
- Simultaneous output pop and input push in a full pipeline: both occur, with no loss or duplication.
- Inputs are ignored when `valid_i = 0` or `ready_o = 0`. Order is preserved.
- Reset (asynchronous, any time, including mid-stall):
  - Immediately forces `valid_o = 0`, stage valids 0, and all data outputs/flags 0.
  - `ready_o = 1` while held in reset and after release.
  - In-flight items are discarded.

## Test plan
All scenarios use default parameters (guard = bit 58, sticky = bits 57:0).
- **RNE tie to even:**
  - kept LSB 0, guard 1, sticky 0 → mantissa unchanged, flags 5'b00001.
  - Same with kept LSB 1 → mantissa + 1, flags 5'b00001.
- **Carry-out:** kept all ones, guard 1, rm RUP, sign 0, exponent 100 → exponent 101, mantissa `1<<52`, flags 5'b00001.
- **Overflow per mode:**
  - exponent 2046, kept all ones, guard 1, RNE → exponent 2047, mantissa 0, flags 5'b00101.
  - `overflow_i = 1` with RTZ → exponent 2046, mantissa all ones, flags 5'b00101.
  - RDN with sign 0 → max finite; RDN with sign 1 → Inf.
- **Exact and underflow:**
  - guard 0, sticky 0 → all five modes give an identical result, flags 0.
  - exponent 0 with sticky 1 → flags 5'b00011.
  - rm 7 → RNE result with NV set.
- **Backpressure:**
  - Stream 6 back-to-back inputs with `ready_i` low for cycles 3–5 → `ready_o` drops once both stages are full.
  - All 6 results emerge in order with no duplicates, and held outputs are stable during the stall.
- **Reset mid-operation:** assert `arst_ni` low while `valid_o = 1` and stalled → `valid_o` and data go to 0 without waiting for a clock. After release, the first new input appears 2 cycles after acceptance.
